// File: rtl/fast_pkg.sv
// fast_pkg: shared types and constants for the FAST front-end.
// Pixel width, fetch FSM encoding and the word packing helper.
package fast_pkg;

  localparam int PIXEL_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  function automatic int pix_per_word(input int data_w);
    return data_w / PIXEL_W;
  endfunction

endpackage

// File: rtl/sram_fetch_fifo.sv
// sram_fetch_fifo: 2-entry synchronous word FIFO for returned SRAM data.
// Pushes while full and pops while empty are dropped.
module sram_fetch_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wp_q, wp_d;
  logic         rp_q, rp_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (do_push) begin
      mem_d[wp_q] = din;
      wp_d        = ~wp_q;
    end
    if (do_pop) begin
      rp_d = ~rp_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rp_q];
  assign empty = (cnt_q == 2'd0);
  assign full  = (cnt_q == 2'd2);
  assign count = cnt_q;

endmodule

// File: rtl/sram_pixel_fetch.sv
// sram_pixel_fetch: raster reader from packed-pixel SRAM to a pixel stream.
// Define SRAM_FETCH_STATS_EN to add the stall_cnt output.
module sram_pixel_fetch
  import fast_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DIM_W-1:0]      img_w,
  input  logic [DIM_W-1:0]      img_h,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ren,
  output logic                  sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_rdat,
  output logic [PIXEL_W-1:0]    pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DIM_W-1:0]      pix_x,
  output logic [DIM_W-1:0]      pix_y,
  output logic                  pix_last
`ifdef SRAM_FETCH_STATS_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int PPW   = pix_per_word(DATA_WIDTH);
  localparam int SUB_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int TW    = 2 * DIM_W;

  localparam logic [TW:0]      ONE_T    = (TW+1)'(1);
  localparam logic [TW:0]      PPW_T    = (TW+1)'(PPW);
  localparam logic [TW-1:0]    ONE_I    = TW'(1);
  localparam logic [DIM_W-1:0] ONE_D    = DIM_W'(1);
  localparam logic [SUB_W-1:0] ONE_S    = SUB_W'(1);
  localparam logic [SUB_W-1:0] LAST_SUB = SUB_W'(PPW - 1);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DIM_W-1:0]      w_q, w_d;
  logic [DIM_W-1:0]      h_q, h_d;
  logic [DIM_W-1:0]      x_q, x_d;
  logic [DIM_W-1:0]      y_q, y_d;
  logic [TW:0]           words_q, words_d;
  logic [TW-1:0]         issue_q, issue_d;
  logic [SUB_W-1:0]      sub_q, sub_d;
  logic                  infl_q;

  logic [TW-1:0]         tot_pix;
  logic                  ren, hs, pop, last_pix, x_end;
  logic [DATA_WIDTH-1:0] head;
  logic                  empty, full;
  logic [1:0]            count;

  // Data lands in the FIFO the cycle after its read was issued.
  sram_fetch_fifo #(
    .W(DATA_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (infl_q),
    .pop  (pop),
    .din  (sram_rdat),
    .dout (head),
    .empty(empty),
    .full (full),
    .count(count)
  );

  assign tot_pix   = TW'(img_w) * TW'(img_h);
  assign pix_valid = !empty;
  assign hs        = pix_valid && pix_ready;
  assign x_end     = (x_q == w_q - ONE_D);
  assign last_pix  = pix_valid && x_end && (y_q == h_q - ONE_D);
  assign pop       = hs && (sub_q == LAST_SUB || last_pix);
  assign ren       = (state_q == FETCH) && !full &&
                     ({1'b0, count} + {2'b00, infl_q} < 3'd2);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    words_d = words_q;
    issue_d = issue_q;
    sub_d   = sub_q;
    if (hs) begin
      sub_d = pop ? '0 : sub_q + ONE_S;
      if (x_end) begin
        x_d = '0;
        y_d = y_q + ONE_D;
      end else begin
        x_d = x_q + ONE_D;
      end
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          w_d     = img_w;
          h_d     = img_h;
          x_d     = '0;
          y_d     = '0;
          sub_d   = '0;
          issue_d = '0;
          words_d = ({1'b0, tot_pix} + PPW_T - ONE_T) / PPW_T;
          state_d = (tot_pix == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (ren) begin
          issue_d = issue_q + ONE_I;
          if ({1'b0, issue_q} == words_q - ONE_T) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (hs && last_pix) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      words_q <= '0;
      issue_q <= '0;
      sub_q   <= '0;
      infl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x_q     <= x_d;
      y_q     <= y_d;
      words_q <= words_d;
      issue_q <= issue_d;
      sub_q   <= sub_d;
      infl_q  <= ren;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sram_ren  = ren;
  assign sram_wen  = 1'b0;
  assign sram_addr = base_q + ADDR_WIDTH'(issue_q);
  assign pix_data  = head[sub_q*PIXEL_W +: PIXEL_W];
  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_last  = last_pix;

`ifdef SRAM_FETCH_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (pix_valid && !pix_ready && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
